// File: rtl/character_fsm.sv
// character_fsm: per-player move/attack/stun state machine feeding the fight controller.
// Define CHAR_PUSHBACK_EN to knock x_pos back by PUSHBACK on hitstun entry.
module character_fsm #(
   parameter logic [9:0] START_X    = 10'd100,
   parameter logic [9:0] Y_POS      = 10'd300,
   parameter bit         FACE_RIGHT = 1'b1,
   parameter logic [9:0] MOVE_STEP  = 10'd3,
   parameter logic [9:0] X_MIN      = 10'd0,
   parameter logic [9:0] X_MAX      = 10'd576,
   parameter logic [9:0] CHAR_W     = 10'd64,
   parameter logic [9:0] REACH      = 10'd48,
   parameter logic [9:0] DIR_REACH  = 10'd64,
   parameter logic [9:0] PUSHBACK   = 10'd16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic       input_active,
   input  logic       btn_left,
   input  logic       btn_right,
   input  logic       btn_attack,
   input  logic [9:0] opp_x_pos,
   input  logic [3:0] opp_state,
   input  logic [4:0] load_frame,
   output logic [9:0] x_pos,
   output logic [9:0] y_pos,
   output logic [3:0] state,
   output logic [1:0] frame_state,
   output logic [4:0] frameCounter
);
   typedef enum logic [3:0] {
      S_IDLE, S_LEFT, S_RIGHT, S_ATK_START, S_ATK_ACTIVE, S_ATK_REC,
      S_DIR_START, S_DIR_ACTIVE, S_DIR_REC, S_STUN
   } state_t;
`ifdef CHAR_PUSHBACK_EN
   localparam bit PUSH_EN = 1'b1;
`else
   localparam bit PUSH_EN = 1'b0;
`endif
   state_t     state_q, nxt;
   logic [9:0] x_q, gap, lx, rx, px;
   logic [1:0] fs_q, cap_q;
   logic [4:0] fc_q, stun_q;
   logic       latch_q, l, r, a, back, opp_act, contact, accept, blocking;
   assign l = input_active & btn_left;
   assign r = input_active & btn_right;
   assign a = input_active & btn_attack;
   assign back = FACE_RIGHT ? l : r;
   assign gap = x_q >= opp_x_pos ? x_q - opp_x_pos : opp_x_pos - x_q;
   assign opp_act = opp_state == S_ATK_ACTIVE || opp_state == S_DIR_ACTIVE;
   assign contact = (opp_state == S_ATK_ACTIVE && gap <= CHAR_W + REACH) ||
                    (opp_state == S_DIR_ACTIVE && gap <= CHAR_W + DIR_REACH);
   assign accept = contact && !latch_q && state_q != S_STUN;
   assign blocking = back && (state_q == S_IDLE || state_q == S_LEFT || state_q == S_RIGHT);
   // Step candidates, clamped to the arena and then to CHAR_W separation from the opponent.
   always_comb begin
      rx = ({1'b0, x_q} + {1'b0, MOVE_STEP} > {1'b0, X_MAX}) ? X_MAX : x_q + MOVE_STEP;
      if (x_q < opp_x_pos && {1'b0, rx} + {1'b0, CHAR_W} > {1'b0, opp_x_pos}) rx = opp_x_pos - CHAR_W;
      lx = (x_q < X_MIN + MOVE_STEP) ? X_MIN : x_q - MOVE_STEP;
      if (x_q > opp_x_pos && {1'b0, lx} < {1'b0, opp_x_pos} + {1'b0, CHAR_W}) lx = opp_x_pos + CHAR_W;
      px = x_q <= opp_x_pos ? ((x_q < X_MIN + PUSHBACK) ? X_MIN : x_q - PUSHBACK)
                            : (({1'b0, x_q} + {1'b0, PUSHBACK} > {1'b0, X_MAX}) ? X_MAX : x_q + PUSHBACK);
   end
   always_comb begin
      nxt = state_q;
      case (state_q)
         S_IDLE, S_LEFT, S_RIGHT:
            nxt = (a && (l || r)) ? S_DIR_START : a ? S_ATK_START :
                  (l && !r) ? S_LEFT : (r && !l) ? S_RIGHT : S_IDLE;
         S_ATK_START:  nxt = fc_q == 5'd4  ? S_ATK_ACTIVE : state_q;
         S_ATK_ACTIVE: nxt = fc_q == 5'd1  ? S_ATK_REC    : state_q;
         S_ATK_REC:    nxt = fc_q == 5'd15 ? S_IDLE       : state_q;
         S_DIR_START:  nxt = fc_q == 5'd3  ? S_DIR_ACTIVE : state_q;
         S_DIR_ACTIVE: nxt = fc_q == 5'd2  ? S_DIR_REC    : state_q;
         S_DIR_REC:    nxt = fc_q == 5'd14 ? S_IDLE       : state_q;
         S_STUN:       nxt = stun_q == 5'd0 ? S_IDLE      : state_q;
         default:      nxt = S_IDLE;
      endcase
   end
   // Stun entry runs on clk: pulse, clear, then capture the controller's load_frame.
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q <= S_IDLE;
         x_q     <= START_X;
         fs_q    <= 2'd0;
         fc_q    <= 5'd0;
         stun_q  <= 5'd0;
         latch_q <= 1'b0;
         cap_q   <= 2'd0;
      end else begin
         latch_q <= opp_act & (latch_q | contact);
         if (accept) begin
            state_q <= S_STUN;
            fc_q    <= 5'd0;
            cap_q   <= 2'd1;
            fs_q    <= blocking ? 2'd2 : 2'd1;
            if (PUSH_EN && !blocking) x_q <= px;
         end else if (cap_q == 2'd1) begin
            fs_q  <= 2'd0;
            cap_q <= 2'd2;
         end else if (cap_q == 2'd2) begin
            stun_q <= load_frame;
            cap_q  <= 2'd0;
         end else if (tick) begin
            state_q <= nxt;
            fc_q    <= nxt != state_q ? 5'd0 : fc_q == 5'd31 ? fc_q : fc_q + 5'd1;
            if (state_q == S_STUN && stun_q != 5'd0) stun_q <= stun_q - 5'd1;
            if (nxt == S_LEFT) x_q <= lx;
            else if (nxt == S_RIGHT) x_q <= rx;
         end
      end
   assign x_pos = x_q;
   assign y_pos = Y_POS;
   assign state = state_q;
   assign frame_state = fs_q;
   assign frameCounter = fc_q;
endmodule

// File: tb/tb_character_fsm.sv
// tb_character_fsm: vector table for movement/attacks plus hand sequences for stun entry.
module tb_character_fsm;
   logic       clk = 1'b0, rst = 1'b1, tick = 1'b0, input_active = 1'b1;
   logic       btn_left = 1'b0, btn_right = 1'b0, btn_attack = 1'b0;
   logic [9:0] opp_x_pos = 10'd500;
   logic [3:0] opp_state = 4'd0;
   logic [4:0] load_frame = 5'd0;
   logic [9:0] x_pos, y_pos;
   logic [3:0] state;
   logic [1:0] frame_state;
   logic [4:0] frameCounter;
   int total = 0, bad = 0, pulses;
   typedef struct {
      logic l, r, a, ia;
      logic [9:0] ox;
      int n;
      logic [3:0] st;
      logic [9:0] x;
      logic [4:0] fc;
   } vec_t;
   vec_t v[23];
   character_fsm dut (
      .clk(clk), .rst(rst), .tick(tick), .input_active(input_active),
      .btn_left(btn_left), .btn_right(btn_right), .btn_attack(btn_attack),
      .opp_x_pos(opp_x_pos), .opp_state(opp_state), .load_frame(load_frame),
      .x_pos(x_pos), .y_pos(y_pos), .state(state), .frame_state(frame_state),
      .frameCounter(frameCounter)
   );
   always #5 clk = ~clk;
   task automatic tk();
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      @(negedge clk);
   endtask
   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d", n, act, exp);
      end
   endtask
   task automatic do_reset();
      rst = 1'b1;
      {btn_left, btn_right, btn_attack, tick} = 4'b0;
      input_active = 1'b1;
      opp_x_pos = 10'd200;
      opp_state = 4'd0;
      load_frame = 5'd0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask
   initial begin
      v[0]  = '{1'b0, 1'b1, 1'b0, 1'b1, 10'd500, 10,  4'd2, 10'd130, 5'd9};
      v[1]  = '{1'b0, 1'b1, 1'b0, 1'b1, 10'd500, 102, 4'd2, 10'd436, 5'd31};
      v[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, 10'd500, 5,   4'd2, 10'd436, 5'd31};
      v[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 10'd500, 1,   4'd0, 10'd436, 5'd0};
      v[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 10'd500, 2,   4'd1, 10'd430, 5'd1};
      v[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 10'd500, 1,   4'd0, 10'd430, 5'd0};
      v[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 10'd500, 3,   4'd0, 10'd430, 5'd3};
      v[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 10'd500, 1,   4'd6, 10'd430, 5'd0};
      v[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 10'd500, 3,   4'd6, 10'd430, 5'd3};
      v[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 10'd500, 1,   4'd7, 10'd430, 5'd0};
      v[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 10'd500, 3,   4'd8, 10'd430, 5'd0};
      v[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 10'd500, 14,  4'd8, 10'd430, 5'd14};
      v[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 10'd500, 1,   4'd0, 10'd430, 5'd0};
      v[13] = '{1'b1, 1'b0, 1'b0, 1'b1, 10'd500, 1,   4'd1, 10'd427, 5'd0};
      v[14] = '{1'b1, 1'b0, 1'b0, 1'b1, 10'd500, 150, 4'd1, 10'd0,   5'd31};
      v[15] = '{1'b0, 1'b1, 1'b0, 1'b1, 10'd101, 20,  4'd2, 10'd37,  5'd19};
      v[16] = '{1'b0, 1'b0, 1'b1, 1'b1, 10'd101, 1,   4'd3, 10'd37,  5'd0};
      v[17] = '{1'b0, 1'b1, 1'b1, 1'b0, 10'd101, 4,   4'd3, 10'd37,  5'd4};
      v[18] = '{1'b0, 1'b0, 1'b0, 1'b0, 10'd101, 1,   4'd4, 10'd37,  5'd0};
      v[19] = '{1'b0, 1'b0, 1'b0, 1'b1, 10'd101, 1,   4'd4, 10'd37,  5'd1};
      v[20] = '{1'b0, 1'b0, 1'b0, 1'b1, 10'd101, 1,   4'd5, 10'd37,  5'd0};
      v[21] = '{1'b0, 1'b0, 1'b0, 1'b1, 10'd101, 15,  4'd5, 10'd37,  5'd15};
      v[22] = '{1'b0, 1'b0, 1'b0, 1'b1, 10'd101, 1,   4'd0, 10'd37,  5'd0};
      repeat (2) @(negedge clk);
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_x", 32'(x_pos), 32'd100);
      chk("rst_y", 32'(y_pos), 32'd300);
      chk("rst_fs", 32'(frame_state), 32'd0);
      chk("rst_fc", 32'(frameCounter), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 23; i++) begin
         {btn_left, btn_right, btn_attack, input_active} = {v[i].l, v[i].r, v[i].a, v[i].ia};
         opp_x_pos = v[i].ox;
         repeat (v[i].n) tk();
         chk($sformatf("v%0d_state", i), 32'(state), 32'(v[i].st));
         chk($sformatf("v%0d_x", i), 32'(x_pos), 32'(v[i].x));
         chk($sformatf("v%0d_fc", i), 32'(frameCounter), 32'(v[i].fc));
      end
      // neutral hit from idle, stun of 18
      do_reset();
      opp_x_pos = 10'd164;
      load_frame = 5'd18;
      opp_state = 4'd4;
      @(negedge clk);
      chk("hit_fs", 32'(frame_state), 32'd1);
      chk("hit_state", 32'(state), 32'd9);
`ifdef CHAR_PUSHBACK_EN
      chk("hit_push_x", 32'(x_pos), 32'd84);
`else
      chk("hit_push_x", 32'(x_pos), 32'd100);
`endif
      opp_state = 4'd0;
      @(negedge clk);
      chk("hit_fs_clear", 32'(frame_state), 32'd0);
      @(negedge clk);
      repeat (18) tk();
      chk("stun18_hold", 32'(state), 32'd9);
      tk();
      chk("stun18_exit", 32'(state), 32'd0);
      chk("stun18_fc", 32'(frameCounter), 32'd0);
      // block with back held; single pulse across a long active phase and during stun
      do_reset();
      btn_left = 1'b1;
      load_frame = 5'd20;
      opp_state = 4'd4;
      @(negedge clk);
      chk("blk_fs", 32'(frame_state), 32'd2);
      chk("blk_state", 32'(state), 32'd9);
      chk("blk_x", 32'(x_pos), 32'd100);
      pulses = 0;
      for (int k = 0; k < 8; k++) begin
         tick = k[0];
         @(negedge clk);
         if (frame_state != 2'd0) pulses++;
      end
      tick = 1'b0;
      opp_state = 4'd0;
      @(negedge clk);
      opp_state = 4'd4;
      repeat (3) begin
         @(negedge clk);
         if (frame_state != 2'd0) pulses++;
      end
      chk("blk_one_pulse", 32'(pulses), 32'd0);
      chk("blk_still_stun", 32'(state), 32'd9);
      // directional hit at gap 120, zero-length stun
      do_reset();
      opp_x_pos = 10'd220;
      opp_state = 4'd7;
      @(negedge clk);
      chk("dir120_fs", 32'(frame_state), 32'd1);
      chk("dir120_state", 32'(state), 32'd9);
      opp_state = 4'd0;
      repeat (2) @(negedge clk);
      tk();
      chk("lf0_exit", 32'(state), 32'd0);
      // directional out of range at gap 129
      do_reset();
      opp_x_pos = 10'd229;
      opp_state = 4'd7;
      repeat (3) @(negedge clk);
      chk("dir129_fs", 32'(frame_state), 32'd0);
      chk("dir129_state", 32'(state), 32'd0);
      // contact and own attack start on the same tick
      do_reset();
      btn_attack = 1'b1;
      opp_state = 4'd4;
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      chk("simul_state", 32'(state), 32'd9);
      chk("simul_fs", 32'(frame_state), 32'd1);
      // mid-attack contact is a hit even with back held
      do_reset();
      btn_attack = 1'b1;
      tk();
      btn_attack = 1'b0;
      btn_left = 1'b1;
      chk("midatk_start", 32'(state), 32'd3);
      opp_state = 4'd4;
      @(negedge clk);
      chk("midatk_fs", 32'(frame_state), 32'd1);
      // asynchronous reset mid-stun
      rst = 1'b1;
      #1;
      chk("arst_state", 32'(state), 32'd0);
      chk("arst_x", 32'(x_pos), 32'd100);
      chk("arst_fs", 32'(frame_state), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/character_fsm.md
Name: character_fsm

Overview:
- Per-player character state machine; two instances (P1, P2) sit directly upstream of the fight controller.
- Converts debounced buttons into movement, neutral attacks and directional attacks; detects incoming hits and blocks against the opponent.
- Produces the state, frame_state and frameCounter signals the fight controller consumes.
- Consumes the fight controller's load_frame to size stun duration.

Parameters:
- START_X, 10'd100: x_pos after reset.
- Y_POS, 10'd300: constant y_pos.
- FACE_RIGHT, 1: 1 means the opponent is to the right, so "back" is btn_left. 0 reverses this.
- MOVE_STEP, 10'd3: pixels moved per tick in S_LEFT/S_RIGHT.
- X_MIN, 10'd0 / X_MAX, 10'd576: x_pos clamp bounds, inclusive.
- CHAR_W, 10'd64: sprite width, used for the overlap guard.
- REACH, 10'd48 / DIR_REACH, 10'd64: hit range of neutral / directional attack, in pixels beyond CHAR_W.
- PUSHBACK, 10'd16: knockback distance (optional feature only).

Ports:
- clk  in  1: system clock.
- rst  in  1: asynchronous reset, active-high.
- tick  in  1: one-clk frame-advance pulse (60 Hz strobe or button clock, selected upstream).
- input_active  in  1: fight controller input enable. When 0, all buttons are treated as 0.
- btn_left, btn_right, btn_attack  in  1 each: debounced levels.
- opp_x_pos  in  10: opponent x.
- opp_state  in  4: opponent state.
- load_frame  in  5: stun length from the fight controller.
- x_pos  out  10: character x position.
- y_pos  out  10: character y position.
- state  out  4: IDLE=0, LEFT=1, RIGHT=2, ATK_START=3, ATK_ACTIVE=4, ATK_REC=5, DIR_START=6, DIR_ACTIVE=7, DIR_REC=8, STUN=9.
- frame_state  out  2: NOHIT=0, HITSTUN=1, BLOCKSTUN=2.
- frameCounter  out  5: ticks elapsed in the current state.

Behaviour:
- Reset: state=IDLE, x_pos=START_X, y_pos=Y_POS, frame_state=NOHIT, frameCounter=0, hit latch clear, stun counter 0.
- Timing: all transitions occur only on clk edges with tick=1, except the stun entry/capture sequence, which is clk-based.
- frameCounter: 0 on every state entry; +1 per tick; saturates at 31.
- IDLE/LEFT/RIGHT each tick, priority high to low:
  - attack with fwd or back held -> DIR_START;
  - attack alone -> ATK_START;
  - left only -> LEFT;
  - right only -> RIGHT;
  - both or none -> IDLE.
- Movement in LEFT/RIGHT: x moves by MOVE_STEP per tick, clamped to [X_MIN, X_MAX].
- Overlap guard: a move that would bring |x_pos - opp_x_pos| below CHAR_W is clamped to exactly CHAR_W separation.
- Neutral attack phases: ATK_START 5 ticks -> ATK_ACTIVE 2 ticks -> ATK_REC 16 ticks -> IDLE. Exit when frameCounter == length-1 on a tick.
- Directional attack phases: DIR_START 4 -> DIR_ACTIVE 3 -> DIR_REC 15 -> IDLE.
- Buttons are ignored during attacks and stun.
- Incoming contact: opp_state is ATK_ACTIVE with gap <= CHAR_W+REACH, or DIR_ACTIVE with gap <= CHAR_W+DIR_REACH. Gap = |x_pos - opp_x_pos|.
- Hit latch: contact is accepted once per opponent active phase; the latch clears when opp_state is neither active state.
- Block vs hit on contact:
  - Block: own state is IDLE, LEFT or RIGHT, and the back button is held.
  - Hit: any other case, including mid-attack.
- Stun entry (clk-level, independent of tick):
  - cycle 0: state=STUN, frame_state = HITSTUN or BLOCKSTUN for exactly one clk;
  - cycle 1: frame_state=NOHIT;
  - cycle 2: stun counter <= load_frame (the fight controller registers load_frame one cycle after seeing the pulse).
- Stun countdown: decrements per tick; counter==0 on a tick -> IDLE.
- load_frame=0 exits on the first tick after capture.
- Contact during STUN: ignored; no new pulse.
- Simultaneous contact and own attack start on the same tick: contact wins.
- input_active=0 mid-attack or mid-stun: the sequence completes; no new actions start.
- rst mid-operation: immediate return to reset values.

Optional Feature:
- Macro: CHAR_PUSHBACK_EN.
- Defined: on HITSTUN entry, x_pos moves PUSHBACK away from the opponent in the same cycle, clamped to X_MIN/X_MAX. No push on BLOCKSTUN.
- Undefined: x_pos unchanged by hits.

Test Plan:
- Hold btn_right 10 ticks from reset, opponent at 500, FACE_RIGHT=1 -> x_pos=130, state=RIGHT. Continue until x reaches 436 -> stays at 436.
- btn_attack for one tick -> state sequence 3,4,5,0 with durations 5/2/16 ticks; frameCounter 0..4, 0..1, 0..15.
- Opponent ATK_ACTIVE at gap 100, own IDLE, no buttons -> frame_state=1 for exactly one clk, state=9. Then load_frame=18 -> 19 ticks later state=0.
- Same contact with btn_left held -> frame_state=2 one clk, state=9. Opponent staying in ATK_ACTIVE for 2 ticks -> only one pulse.
- Opponent DIR_ACTIVE at gap 120 -> hit. Same at gap 129 -> no response.
- CHAR_PUSHBACK_EN defined, x=100, opponent at 164 to the right, hit -> x_pos=84. x=10 -> x_pos=0.
